// File: rtl/control_unit_if.sv
// Control bus between the main decoder and the datapath.
// The master drives every select/enable; the slave returns the ALU zero flag.
interface control_bus_if;
    logic       rf_we;
    logic [1:0] sel_wa;
    logic       sel_alu_b;
    logic       dmem_we;
    logic [1:0] sel_result;
    logic [1:0] sel_pc;
    logic       branch;
    logic [1:0] alu_op;
    logic [3:0] alu_ctrl;
    logic       hilo_we;
    logic       sel_hilo;
    logic       zero;

    modport master (
        output rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc,
               branch, alu_op, alu_ctrl, hilo_we, sel_hilo,
        input  zero
    );

    modport slave (
        input  rf_we, sel_wa, sel_alu_b, dmem_we, sel_result, sel_pc,
               branch, alu_op, alu_ctrl, hilo_we, sel_hilo,
        output zero
    );
endinterface

// File: rtl/control_unit.sv
// Main decoder of the single-cycle MIPS core: combinational opcode/funct decode
// onto the control bus, plus a sticky illegal-instruction flag.
package control_signals;
    // {rf_we, sel_wa[1:0], sel_alu_b, dmem_we, sel_result[1:0], sel_pc[1:0], branch, alu_op[1:0]}
    typedef logic [11:0] control_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_JR    = 6'h08;
    localparam logic [5:0] FUNCT_MFHI  = 6'h10;
    localparam logic [5:0] FUNCT_MFLO  = 6'h12;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_SUB   = 6'h22;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULTU = 4'b1000;
    localparam logic [3:0] ALU_DIVU  = 4'b1001;

    localparam control_t NOPc   = 12'b0_00_0_0_00_00_0_00;
    localparam control_t LWc    = 12'b1_00_1_0_01_00_0_00;
    localparam control_t SWc    = 12'b0_00_1_1_00_00_0_00;
    localparam control_t ADDIc  = 12'b1_00_1_0_00_00_0_00;
    localparam control_t Jc     = 12'b0_00_0_0_00_10_0_00;
    localparam control_t JALc   = 12'b1_10_0_0_10_10_0_00;
    localparam control_t BEQc   = 12'b0_00_0_0_00_01_1_01;
    localparam control_t JRc    = 12'b0_00_0_0_00_11_0_10;
    localparam control_t RTYPEc = 12'b1_01_0_0_00_00_0_10;
    localparam control_t MFHIc  = 12'b1_01_0_0_11_00_0_10;
    localparam control_t MFLOc  = 12'b1_01_0_0_11_00_0_10;
    localparam control_t MULTUc = 12'b0_00_0_0_00_00_0_10;
endpackage

module control_unit
    import control_signals::*;
(
    input  logic          clock,
    input  logic          reset_n,
    input  logic [5:0]    opcode,
    input  logic [5:0]    funct,
    control_bus_if.master control_bus,
    output logic          illegal_instr
);

    control_t   ctrl_s;
    logic       hilo_we_s;
    logic       sel_hilo_s;
    logic       legal_s;
    logic [3:0] alu_ctrl_s;
    logic       illegal_r;
    logic       unused_zero_s;

    // The zero flag only qualifies branches in the datapath; decode ignores it.
    assign unused_zero_s = control_bus.zero;

    // Main decode: opcode, then funct for R-type; anything unrecognised is a NOP.
    always_comb begin
        ctrl_s     = NOPc;
        hilo_we_s  = 1'b0;
        sel_hilo_s = 1'b0;
        legal_s    = 1'b1;
        case (opcode)
            OP_LW:   ctrl_s = LWc;
            OP_SW:   ctrl_s = SWc;
            OP_ADDI: ctrl_s = ADDIc;
            OP_J:    ctrl_s = Jc;
            OP_JAL:  ctrl_s = JALc;
            OP_BEQ:  ctrl_s = BEQc;
            OP_RTYPE: begin
                case (funct)
                    FUNCT_JR: ctrl_s = JRc;
                    FUNCT_ADD, FUNCT_SUB, FUNCT_OR, FUNCT_SLT: ctrl_s = RTYPEc;
                    FUNCT_MFHI: ctrl_s = MFHIc;
                    FUNCT_MFLO: begin
                        ctrl_s     = MFLOc;
                        sel_hilo_s = 1'b1;
                    end
                    FUNCT_MULTU, FUNCT_DIVU: begin
                        ctrl_s    = MULTUc;
                        hilo_we_s = 1'b1;
                    end
                    default: legal_s = 1'b0;
                endcase
            end
            default: legal_s = 1'b0;
        endcase
    end

    // ALU control from alu_op; forced to zero so an illegal NOP drives an all-zero bus.
    always_comb begin
        alu_ctrl_s = ALU_ADD;
        if (!legal_s) begin
            alu_ctrl_s = 4'b0000;
        end else begin
            case (ctrl_s[1:0])
                ALUOP_ADD: alu_ctrl_s = ALU_ADD;
                ALUOP_SUB: alu_ctrl_s = ALU_SUB;
                ALUOP_FUNCT: begin
                    case (funct)
                        FUNCT_ADD:   alu_ctrl_s = ALU_ADD;
                        FUNCT_SUB:   alu_ctrl_s = ALU_SUB;
                        FUNCT_OR:    alu_ctrl_s = ALU_OR;
                        FUNCT_SLT:   alu_ctrl_s = ALU_SLT;
                        FUNCT_MULTU: alu_ctrl_s = ALU_MULTU;
                        FUNCT_DIVU:  alu_ctrl_s = ALU_DIVU;
                        default:     alu_ctrl_s = ALU_ADD;
                    endcase
                end
                default: alu_ctrl_s = ALU_ADD;
            endcase
        end
    end

    // Sticky illegal-instruction flag, cleared only by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            illegal_r <= 1'b0;
        end else if (!legal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign {control_bus.rf_we, control_bus.sel_wa, control_bus.sel_alu_b,
            control_bus.dmem_we, control_bus.sel_result, control_bus.sel_pc,
            control_bus.branch, control_bus.alu_op} = ctrl_s;
    assign control_bus.alu_ctrl = alu_ctrl_s;
    assign control_bus.hilo_we  = hilo_we_s;
    assign control_bus.sel_hilo = sel_hilo_s;
    assign illegal_instr        = illegal_r;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a table-driven instruction model predicts
// every bus field and the sticky flag; a negedge monitor compares.
module tb_control_unit;

    logic       clock;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       illegal_instr;

    control_bus_if cb ();

    control_unit dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .funct         (funct),
        .control_bus   (cb.master),
        .illegal_instr (illegal_instr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [18:0] exp;
    } sb_item_t;

    sb_item_t sb[$];
    int checks = 0;
    int errors = 0;

    // Instruction table: opcode, funct (R-type only) and the expected field values.
    localparam int NINSTR = 15;
    logic [5:0]  t_op   [NINSTR];
    logic [5:0]  t_fn   [NINSTR];
    logic [17:0] t_word [NINSTR];

    bit sticky_m;
    bit prev_ill;

    function automatic logic [17:0] fields(input logic rf, input logic [1:0] wa,
            input logic b, input logic dwe, input logic [1:0] res, input logic [1:0] pc,
            input logic br, input logic [1:0] aop, input logic [3:0] actl,
            input logic hwe, input logic sh);
        return {rf, wa, b, dwe, res, pc, br, aop, actl, hwe, sh};
    endfunction

    function automatic int lookup(input logic [5:0] op, input logic [5:0] fn);
        for (int i = 0; i < NINSTR; i++)
            if (t_op[i] == op && (op != 6'h00 || t_fn[i] == fn)) return i;
        return -1;
    endfunction

    function automatic logic [17:0] model_word(input logic [5:0] op, input logic [5:0] fn);
        int idx;
        idx = lookup(op, fn);
        if (idx < 0) return 18'd0;
        return t_word[idx];
    endfunction

    function automatic logic [18:0] bus_now();
        return {cb.rf_we, cb.sel_wa, cb.sel_alu_b, cb.dmem_we, cb.sel_result, cb.sel_pc,
                cb.branch, cb.alu_op, cb.alu_ctrl, cb.hilo_we, cb.sel_hilo, illegal_instr};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Hold the previous instruction through a rising edge, then present a new one.
    task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic z);
        sb_item_t it;
        @(posedge clock);
        sticky_m = sticky_m | prev_ill;
        #1;
        opcode  = op;
        funct   = fn;
        cb.zero = z;
        it.op  = op;
        it.fn  = fn;
        it.exp = {model_word(op, fn), sticky_m};
        sb.push_back(it);
        prev_ill = (lookup(op, fn) < 0);
    endtask

    // Monitor: compare the live bus against the oldest prediction.
    initial begin
        sb_item_t it;
        logic [18:0] act;
        forever begin
            @(negedge clock);
            if (sb.size() > 0) begin
                it  = sb.pop_front();
                act = bus_now();
                checks++;
                if (act !== it.exp) begin
                    errors++;
                    $display("FAIL decode op=%h fn=%h: got %b expected %b", it.op, it.fn, act, it.exp);
                end
            end
        end
    end

    initial begin
        int idx;
        t_op[0]  = 6'h23; t_fn[0]  = 6'h00; t_word[0]  = fields(1'b1, 2'b00, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0);
        t_op[1]  = 6'h2B; t_fn[1]  = 6'h00; t_word[1]  = fields(1'b0, 2'b00, 1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0);
        t_op[2]  = 6'h08; t_fn[2]  = 6'h00; t_word[2]  = fields(1'b1, 2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0);
        t_op[3]  = 6'h02; t_fn[3]  = 6'h00; t_word[3]  = fields(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b10, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0);
        t_op[4]  = 6'h03; t_fn[4]  = 6'h00; t_word[4]  = fields(1'b1, 2'b10, 1'b0, 1'b0, 2'b10, 2'b10, 1'b0, 2'b00, 4'b0010, 1'b0, 1'b0);
        t_op[5]  = 6'h04; t_fn[5]  = 6'h00; t_word[5]  = fields(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 2'b01, 4'b0110, 1'b0, 1'b0);
        t_op[6]  = 6'h00; t_fn[6]  = 6'h08; t_word[6]  = fields(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b11, 1'b0, 2'b10, 4'b0010, 1'b0, 1'b0);
        t_op[7]  = 6'h00; t_fn[7]  = 6'h20; t_word[7]  = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b0010, 1'b0, 1'b0);
        t_op[8]  = 6'h00; t_fn[8]  = 6'h22; t_word[8]  = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b0110, 1'b0, 1'b0);
        t_op[9]  = 6'h00; t_fn[9]  = 6'h25; t_word[9]  = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b0001, 1'b0, 1'b0);
        t_op[10] = 6'h00; t_fn[10] = 6'h2A; t_word[10] = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b0111, 1'b0, 1'b0);
        t_op[11] = 6'h00; t_fn[11] = 6'h10; t_word[11] = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 4'b0010, 1'b0, 1'b0);
        t_op[12] = 6'h00; t_fn[12] = 6'h12; t_word[12] = fields(1'b1, 2'b01, 1'b0, 1'b0, 2'b11, 2'b00, 1'b0, 2'b10, 4'b0010, 1'b0, 1'b1);
        t_op[13] = 6'h00; t_fn[13] = 6'h19; t_word[13] = fields(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b1000, 1'b1, 1'b0);
        t_op[14] = 6'h00; t_fn[14] = 6'h1B; t_word[14] = fields(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b10, 4'b1001, 1'b1, 1'b0);

        reset_n  = 1'b0;
        opcode   = 6'h00;
        funct    = 6'h20;
        cb.zero  = 1'b0;
        sticky_m = 1'b0;
        prev_ill = 1'b0;
        #8;
        check("reset_flag", {31'd0, illegal_instr}, 32'd0);
        #4;
        reset_n = 1'b1;

        // Directed pass over every instruction; BEQ with both zero values.
        apply(6'h23, 6'h3F, 1'b0);
        apply(6'h2B, 6'h00, 1'b1);
        apply(6'h03, 6'h11, 1'b0);
        apply(6'h02, 6'h11, 1'b1);
        apply(6'h04, 6'h00, 1'b0);
        apply(6'h04, 6'h00, 1'b1);
        for (int i = 6; i < NINSTR; i++) apply(t_op[i], t_fn[i], 1'($urandom_range(0, 1)));
        apply(6'h08, 6'h2A, 1'b0);

        // Random legal instructions, with random funct on non-R-type opcodes.
        for (int i = 0; i < 150; i++) begin
            idx = $urandom_range(0, NINSTR - 1);
            apply(t_op[idx], (t_op[idx] == 6'h00) ? t_fn[idx] : 6'($urandom_range(0, 63)),
                  1'($urandom_range(0, 1)));
        end

        // First illegal opcode, then fully random instructions.
        apply(6'h3F, 6'h00, 1'b0);
        apply(6'h23, 6'h00, 1'b0);
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 0) apply(6'h00, 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
            else apply(6'($urandom_range(0, 63)), 6'($urandom_range(0, 63)), 1'($urandom_range(0, 1)));
        end

        for (int k = 0; k < 4 && sb.size() != 0; k++) @(posedge clock);
        check("scoreboard_drained", sb.size(), 32'd0);

        // Reset clears the flag asynchronously and leaves decode untouched.
        @(posedge clock);
        #1;
        opcode  = 6'h00;
        funct   = 6'h20;
        cb.zero = 1'b0;
        #1;
        check("flag_set_before_reset", {31'd0, illegal_instr}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("async_clear", {31'd0, illegal_instr}, 32'd0);
        check("decode_in_reset", {14'd0, bus_now()[18:1]}, {14'd0, t_word[7]});
        reset_n = 1'b1;
        opcode  = 6'h3F;
        cb.zero = 1'b1;
        #1;
        check("illegal_nop_bus", {14'd0, bus_now()[18:1]}, 32'd0);
        check("flag_before_edge", {31'd0, illegal_instr}, 32'd0);
        @(posedge clock);
        #1;
        check("flag_after_edge", {31'd0, illegal_instr}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("midcycle_clear", {31'd0, illegal_instr}, 32'd0);
        reset_n = 1'b1;
        #1;
        check("held_after_release", {31'd0, illegal_instr}, 32'd0);
        @(posedge clock);
        #1;
        check("set_after_release", {31'd0, illegal_instr}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
